// File: rtl/axis_rr_channel_arbiter_if.sv
// Stream bundle for axis_rr_channel_arbiter.
// Carries the per-channel input streams and the merged output stream.
// Input side (per channel): s_tvalid, s_tready, s_tdata (flattened), s_tlast.
// Output side: m_tdata, m_tkeep, m_tdest, m_tlast, m_tvalid, m_tready.
// The master modport is the arbiter's view. The slave modport is the
// surrounding logic's view: the channel serialisers plus the egress sink.
interface axis_rr_channel_arbiter_if #(
  parameter int NUM_CHANNELS = 5,
  parameter int DATA_WIDTH   = 128,
  parameter int CHAN_BITS    = $clog2(NUM_CHANNELS)
);
  logic [NUM_CHANNELS-1:0]            s_tvalid;
  logic [NUM_CHANNELS-1:0]            s_tready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_CHANNELS-1:0]            s_tlast;
  logic [DATA_WIDTH-1:0]              m_tdata;
  logic [DATA_WIDTH/8-1:0]            m_tkeep;
  logic [CHAN_BITS-1:0]               m_tdest;
  logic                               m_tlast;
  logic                               m_tvalid;
  logic                               m_tready;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tdest, m_tlast, m_tvalid
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tdest, m_tlast, m_tvalid
  );
endinterface

// File: rtl/axis_rr_channel_arbiter.sv
// N-channel round-robin packet arbiter with a registered AXI4-Stream output.
// A grant is held for a whole packet, up to and including tlast. A packet
// that reaches MAX_BEATS beats without tlast is cut off: its last beat goes
// out with m_tlast forced high, and trunc_pulse is raised for one cycle.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   ch_enable    runtime channel enable mask (only sampled while idle)
//   bus          stream bundle, master modport (s_* in, m_* out)
//   busy         high while a multi-beat packet holds the grant
//   grant_idx    current or last granted channel
//   trunc_pulse  one-cycle pulse on a forced packet truncation
module axis_rr_channel_arbiter #(
  parameter int NUM_CHANNELS = 5,
  parameter int DATA_WIDTH   = 128,
  parameter int CHAN_BITS    = $clog2(NUM_CHANNELS),
  parameter int MAX_BEATS    = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] ch_enable,
  axis_rr_channel_arbiter_if.master bus,
  output logic                    busy,
  output logic [CHAN_BITS-1:0]    grant_idx,
  output logic                    trunc_pulse
);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_BEATS);
  localparam logic [CHAN_BITS-1:0] LAST_IDX = CHAN_BITS'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [CHAN_BITS-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [CHAN_BITS-1:0]    m_tdest_q, m_tdest_d;
  logic                    trunc_q, trunc_d;

  logic                    load_ok;
  logic [NUM_CHANNELS-1:0] cand;
  logic [CHAN_BITS-1:0]    idx;
  logic [CHAN_BITS-1:0]    sel;
  logic                    found;
  logic                    gnt_valid;
  logic [CHAN_BITS-1:0]    gnt;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic                    beat_last;
  logic                    beat_valid;
  logic                    hs;
  logic                    trunc;
  logic [CNT_W-1:0]        cnt_inc;
  logic [NUM_CHANNELS-1:0] ready_vec;

  always_comb begin
    load_ok = !m_tvalid_q || bus.m_tready;
    cand    = bus.s_tvalid & ch_enable;

    // Rotating search starting just after the last grant. The wrap is an
    // explicit compare, so a non-power-of-two channel count never selects
    // an index past the last channel.
    idx   = grant_q;
    sel   = grant_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end

    gnt_valid = (state_q == LOCKED) ? 1'b1 : found;
    gnt       = (state_q == LOCKED) ? grant_q : sel;

    beat_data  = '0;
    beat_last  = 1'b0;
    beat_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (CHAN_BITS'(k) == gnt) begin
        beat_data  = bus.s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        beat_last  = bus.s_tlast[k];
        beat_valid = bus.s_tvalid[k];
      end
    end

    // Ready is held low while reset is asserted, so that a beat is never
    // consumed from a source in a cycle whose capture reset then discards.
    ready_vec = '0;
    if (gnt_valid && !reset) begin
      ready_vec[gnt] = load_ok;
    end

    hs      = gnt_valid && load_ok && beat_valid;
    cnt_inc = cnt_q + 1'b1;
    trunc   = hs && !beat_last && (cnt_inc == MAX_CNT);

    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tdest_d  = m_tdest_q;
    trunc_d    = 1'b0;

    if (hs) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = beat_data;
      m_tlast_d  = beat_last || trunc;
      m_tdest_d  = gnt;
      grant_d    = gnt;
      trunc_d    = trunc;
      if (beat_last || trunc) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = LOCKED;
        cnt_d   = cnt_inc;
      end
    end else if (load_ok) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= LAST_IDX;
      cnt_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tdest_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tdest_q  <= m_tdest_d;
      trunc_q    <= trunc_d;
    end
  end

  assign bus.s_tready = ready_vec;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tdest  = m_tdest_q;
  assign bus.m_tkeep  = '1;
  assign busy         = (state_q == LOCKED);
  assign grant_idx    = grant_q;
  assign trunc_pulse  = trunc_q;
endmodule

// File: tb/tb_axis_rr_channel_arbiter.sv
// Directed bench for axis_rr_channel_arbiter (5 channels, 32-bit data,
// MAX_BEATS=4). Per-channel beat lists feed the inputs; accepted output
// beats are collected and compared against hand-written expected lists.
module tb_axis_rr_channel_arbiter;
  localparam int NCH = 5;
  localparam int DW  = 32;
  localparam int CB  = 3;
  localparam int MB  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] ch_enable;
  logic           busy;
  logic [CB-1:0]  grant_idx;
  logic           trunc_pulse;

  axis_rr_channel_arbiter_if #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .CHAN_BITS(CB)) bus ();

  axis_rr_channel_arbiter #(
    .NUM_CHANNELS(NCH),
    .DATA_WIDTH(DW),
    .CHAN_BITS(CB),
    .MAX_BEATS(MB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ch_enable(ch_enable),
    .bus(bus),
    .busy(busy),
    .grant_idx(grant_idx),
    .trunc_pulse(trunc_pulse)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] src_data [NCH][16];
  logic          src_last [NCH][16];
  int unsigned   rd_ptr [NCH];
  int unsigned   wr_ptr [NCH];
  logic [63:0]   obs_q[$];
  logic [63:0]   exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [CB-1:0] dest, input logic last,
                                       input logic [DW-1:0] data);
    return 64'({dest, last, data});
  endfunction

  task automatic push_beat(input int unsigned ch, input logic [DW-1:0] d, input logic l);
    src_data[ch][wr_ptr[ch]] = d;
    src_last[ch][wr_ptr[ch]] = l;
    wr_ptr[ch]++;
  endtask

  task automatic exp_push(input int unsigned ch, input logic l, input logic [DW-1:0] d);
    exp_q.push_back(pack(CB'(ch), l, d));
  endtask

  task automatic clear_src();
    for (int k = 0; k < NCH; k++) begin
      rd_ptr[k] = 0;
      wr_ptr[k] = 0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      if (rd_ptr[k] < wr_ptr[k]) begin
        bus.s_tvalid[k]           = 1'b1;
        bus.s_tdata[k*DW +: DW]   = src_data[k][rd_ptr[k]];
        bus.s_tlast[k]            = src_last[k][rd_ptr[k]];
      end else begin
        bus.s_tvalid[k]           = 1'b0;
        bus.s_tdata[k*DW +: DW]   = '0;
        bus.s_tlast[k]            = 1'b0;
      end
    end
  endtask

  // One clock: record handshakes just before the edge, then advance the
  // sources and let the combinational ready settle.
  task automatic tick();
    logic [NCH-1:0] hs;
    #1;
    hs = bus.s_tvalid & bus.s_tready;
    if (bus.m_tvalid && bus.m_tready)
      obs_q.push_back(pack(bus.m_tdest, bus.m_tlast, bus.m_tdata));
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++)
      if (hs[k]) rd_ptr[k]++;
    drive();
    #1;
  endtask

  task automatic sb_check(input string tag);
    int unsigned n;
    check_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++)
      check_eq(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned seq_a [6];
    seq_a = '{0, 2, 4, 0, 2, 4};

    reset        = 1'b1;
    ch_enable    = '1;
    bus.m_tready = 1'b1;
    clear_src();
    drive();
    tick();
    tick();

    // Reset state
    check_eq("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check_eq("rst_m_tdata",  64'(bus.m_tdata),  64'd0);
    check_eq("rst_m_tlast",  64'(bus.m_tlast),  64'd0);
    check_eq("rst_m_tdest",  64'(bus.m_tdest),  64'd0);
    check_eq("rst_s_tready", 64'(bus.s_tready), 64'd0);
    check_eq("rst_busy",     64'(busy),         64'd0);
    check_eq("rst_trunc",    64'(trunc_pulse),  64'd0);
    check_eq("rst_grant",    64'(grant_idx),    64'd4);
    check_eq("m_tkeep",      64'(bus.m_tkeep),  64'hF);
    reset = 1'b0;

    // Single-beat packets on channels 0, 2, 4
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < NCH; ch += 2) begin
        push_beat(ch, 32'hA000 + 32'(ch * 16 + r), 1'b1);
        exp_push(ch, 1'b1, 32'hA000 + 32'(ch * 16 + r));
      end
    end
    drive();
    #1;
    check_eq("rr_first_ready", 64'(bus.s_tready), 64'b00001);
    check_eq("rr_pre_valid",   64'(bus.m_tvalid), 64'd0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check_eq("rr_valid", 64'(bus.m_tvalid), 64'd1);
      check_eq("rr_dest",  64'(bus.m_tdest),  64'(seq_a[c]));
    end
    tick();
    check_eq("rr_idle_valid", 64'(bus.m_tvalid), 64'd0);
    sb_check("rr_data");

    // 4-beat packet on channel 1 while channel 3 waits
    for (int i = 0; i < 4; i++) begin
      push_beat(1, 32'hB100 + 32'(i), i == 3);
      exp_push(1, i == 3, 32'hB100 + 32'(i));
    end
    push_beat(3, 32'hB300, 1'b1);
    exp_push(3, 1'b1, 32'hB300);
    drive();
    #1;
    check_eq("lock_first_ready", 64'(bus.s_tready), 64'b00010);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("lock_busy",  64'(busy),         64'd1);
      check_eq("lock_ready", 64'(bus.s_tready), 64'b00010);
      check_eq("lock_dest",  64'(bus.m_tdest),  64'd1);
      check_eq("lock_last",  64'(bus.m_tlast),  64'd0);
      tick();
    end
    check_eq("lock_end_last",  64'(bus.m_tlast),  64'd1);
    check_eq("lock_end_busy",  64'(busy),         64'd0);
    check_eq("lock_end_ready", 64'(bus.s_tready), 64'b01000);
    check_eq("lock_end_trunc", 64'(trunc_pulse),  64'd0);
    tick();
    check_eq("lock_next_dest",  64'(bus.m_tdest), 64'd3);
    check_eq("lock_next_grant", 64'(grant_idx),   64'd3);
    tick();
    sb_check("lock_data");

    // Back-pressure mid-packet on channel 0
    for (int i = 0; i < 3; i++) begin
      push_beat(0, 32'hA5000000 + 32'(i), i == 2);
      exp_push(0, i == 2, 32'hA5000000 + 32'(i));
    end
    drive();
    tick();
    tick();
    bus.m_tready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq("stall_valid", 64'(bus.m_tvalid), 64'd1);
      check_eq("stall_data",  64'(bus.m_tdata),  64'hA5000001);
      check_eq("stall_last",  64'(bus.m_tlast),  64'd0);
      check_eq("stall_dest",  64'(bus.m_tdest),  64'd0);
      check_eq("stall_ready", 64'(bus.s_tready), 64'd0);
    end
    bus.m_tready = 1'b1;
    tick();
    check_eq("stall_resume_data", 64'(bus.m_tdata), 64'hA5000002);
    tick();
    check_eq("stall_drained", 64'(bus.m_tvalid), 64'd0);
    sb_check("stall_data");

    // 6-beat packet on channel 2, truncated at 4 beats
    for (int i = 0; i < 6; i++)
      push_beat(2, 32'hD000 + 32'(i), i == 5);
    for (int i = 0; i < 4; i++)
      exp_push(2, i == 3, 32'hD000 + 32'(i));
    exp_push(2, 1'b0, 32'hD004);
    exp_push(2, 1'b1, 32'hD005);
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("trunc_early_pulse", 64'(trunc_pulse), 64'd0);
    end
    tick();
    check_eq("trunc_data",  64'(bus.m_tdata),  64'hD003);
    check_eq("trunc_last",  64'(bus.m_tlast),  64'd1);
    check_eq("trunc_pulse", 64'(trunc_pulse),  64'd1);
    check_eq("trunc_busy",  64'(busy),         64'd0);
    check_eq("trunc_ready", 64'(bus.s_tready), 64'b00100);
    tick();
    check_eq("trunc_pulse_off", 64'(trunc_pulse), 64'd0);
    check_eq("trunc_rest_busy", 64'(busy),        64'd1);
    check_eq("trunc_rest_data", 64'(bus.m_tdata), 64'hD004);
    check_eq("trunc_rest_last", 64'(bus.m_tlast), 64'd0);
    tick();
    check_eq("trunc_tail_last",  64'(bus.m_tlast), 64'd1);
    check_eq("trunc_tail_pulse", 64'(trunc_pulse), 64'd0);
    tick();
    sb_check("trunc_data");

    // Enable mask: channel 0 masked; channel 1 unmasked only before its packet
    ch_enable = 5'b11110;
    push_beat(0, 32'hE000, 1'b1);
    for (int i = 0; i < 3; i++)
      push_beat(1, 32'hE100 + 32'(i), i == 2);
    push_beat(2, 32'hE200, 1'b1);
    push_beat(3, 32'hE300, 1'b1);
    push_beat(4, 32'hE400, 1'b1);
    exp_push(3, 1'b1, 32'hE300);
    exp_push(4, 1'b1, 32'hE400);
    exp_push(1, 1'b0, 32'hE100);
    exp_push(1, 1'b0, 32'hE101);
    exp_push(1, 1'b1, 32'hE102);
    exp_push(2, 1'b1, 32'hE200);
    drive();
    #1;
    check_eq("en_first_ready", 64'(bus.s_tready), 64'b01000);
    tick();
    tick();
    tick();
    check_eq("en_lock_busy",  64'(busy),      64'd1);
    check_eq("en_lock_grant", 64'(grant_idx), 64'd1);
    ch_enable = 5'b11100;
    #1;
    check_eq("en_lock_ready", 64'(bus.s_tready), 64'b00010);
    tick();
    tick();
    check_eq("en_lock_last", 64'(bus.m_tlast), 64'd1);
    check_eq("en_lock_dest", 64'(bus.m_tdest), 64'd1);
    tick();
    check_eq("en_next_dest", 64'(bus.m_tdest), 64'd2);
    tick();
    check_eq("en_idle_valid", 64'(bus.m_tvalid), 64'd0);
    check_eq("en_idle_ready", 64'(bus.s_tready), 64'd0);
    check_eq("en_idle_grant", 64'(grant_idx),    64'd2);
    sb_check("en_data");

    // Reset during beat 2 of a 3-beat packet on channel 3
    clear_src();
    ch_enable = '1;
    for (int i = 0; i < 3; i++)
      push_beat(3, 32'hF000 + 32'(i), i == 2);
    push_beat(1, 32'hF100, 1'b1);
    push_beat(4, 32'hF400, 1'b1);
    exp_push(3, 1'b0, 32'hF000);
    exp_push(1, 1'b1, 32'hF100);
    drive();
    #1;
    check_eq("mrst_first_ready", 64'(bus.s_tready), 64'b01000);
    tick();
    reset = 1'b1;
    tick();
    check_eq("mrst_valid", 64'(bus.m_tvalid), 64'd0);
    check_eq("mrst_busy",  64'(busy),         64'd0);
    check_eq("mrst_grant", 64'(grant_idx),    64'd4);
    check_eq("mrst_last",  64'(bus.m_tlast),  64'd0);
    reset = 1'b0;
    #1;
    check_eq("mrst_ready", 64'(bus.s_tready), 64'b00010);
    tick();
    check_eq("mrst_dest",  64'(bus.m_tdest), 64'd1);
    check_eq("mrst_data",  64'(bus.m_tdata), 64'hF100);
    check_eq("mrst_grant_after", 64'(grant_idx), 64'd1);
    clear_src();
    drive();
    tick();
    sb_check("mrst_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
